hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
- EX-stage controller directly upstream of the multiplier controller.
- Decodes multiply-class and HI/LO-move operations, drives the multiplier's start/sign/operand inputs, and holds a pipeline stall until the multiplier's done pulse.
- Writes or accumulates the 64-bit product into the architectural HI/LO registers.
- Supports MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO.

Parameters:
- DW, 32, operand width; HI/LO are DW each, product is 2*DW.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- op_valid  input  1  EX stage holds a valid instruction this cycle.
- op  input  4  0=NONE, 1=MULT, 2=MULTU, 3=MADD, 4=MADDU, 5=MSUB, 6=MSUBU, 7=MTHI, 8=MTLO; other codes are treated as NONE.
- rs_val  input  DW  first operand; also the MTHI/MTLO source.
- rt_val  input  DW  second operand.
- flush  input  1  abort the current EX instruction (exception/branch flush).
- mul_p  input  2*DW  product from the multiplier.
- mul_over  input  1  multiplier done indication.
- mul_start  output  1  multiplier enable/start.
- mul_sign  output  1  1 selects a signed multiply.
- mul_a  output  DW  multiplier operand A.
- mul_b  output  DW  multiplier operand B.
- stall_req  output  1  stall request to the pipeline controller.
- hi  output  DW  HI register.
- lo  output  DW  LO register.

Behaviour:
- Reset (rst=0, asynchronous): hi=0, lo=0, state=IDLE, mul_start=0, mul_sign=0, mul_a=0, mul_b=0 (registered). stall_req=0 while in reset.
- Multiply class: MULT, MULTU, MADD, MADDU, MSUB, MSUBU. Signed ops: MULT, MADD, MSUB.
- FSM states: IDLE, BUSY.
- IDLE:
  - op_valid & multiply class & ~flush: on that edge, latch rs_val→mul_a, rt_val→mul_b, sign→mul_sign, op→op_r; set mul_start=1; go to BUSY.
  - stall_req=1 combinationally in that issue cycle.
- BUSY:
  - mul_start stays 1 and mul_a/mul_b/mul_sign stay stable.
  - stall_req=1 until completion; stall_req=0 in the cycle mul_over=1 so the pipeline advances on that edge.
  - Completion: mul_over=1 while in BUSY. On that edge:
    - MULT/MULTU: {hi,lo} <= mul_p.
    - MADD/MADDU: {hi,lo} <= {hi,lo} + mul_p.
    - MSUB/MSUBU: {hi,lo} <= {hi,lo} - mul_p.
    - All arithmetic is modulo 2^(2*DW); carries and borrows wrap silently.
    - Then mul_start=0 and state goes to IDLE.
- Back-to-back: a new multiply presented in the cycle after completion issues normally from IDLE. There is at least one cycle with mul_start=0 between operations so the multiplier counter re-arms.
- mul_over is ignored while in IDLE.
- MTHI/MTLO:
  - When op_valid & ~flush in IDLE, write rs_val into hi or lo at the edge.
  - No stall; no multiplier activity.
- flush:
  - IDLE: suppresses any issue or move; no HI/LO write.
  - BUSY: on that edge, go to IDLE with mul_start=0 and no HI/LO write, even if mul_over=1 in the same cycle. stall_req=0 in the flush cycle.
- A stalled EX stage keeps op_valid/op/operands stable while in BUSY; the block ignores changes to them while BUSY.
- Reset mid-operation: immediate return to IDLE with all reset values; the pending product is discarded.
- hi/lo are register outputs. Forwarding to later readers is the pipeline's responsibility.
- Only the multiplier handshake is relied on; multiplier latency is not assumed. Nominal latency with the current multiplier is 3 cycles of mul_start high.

Test Plan:
- Reset check: hold rst=0 with op_valid=1, op=MTHI -> hi=lo=0, stall_req=0, mul_start=0; after release, no spurious writes.
- MULT signed: rs=FFFFFFFD (-3), rt=00000005, multiplier model with a 3-cycle done -> stall_req high exactly until the done cycle; then hi=FFFFFFFF, lo=FFFFFFF1; mul_sign=1 throughout.
- MULTU then MADDU: MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Next MADDU 00000002*00000003 -> hi=FFFFFFFE, lo=00000007; confirm a mul_start low gap between the two operations.
- MSUB wrap: MTHI 0, MTLO 0, then MSUB 1*1 -> hi=FFFFFFFF, lo=FFFFFFFF. Separately, MADD overflow from hi/lo=FFFFFFFF/FFFFFFFF plus 1*1 -> hi=0, lo=0.
- Flush mid-op: issue MULT 7*6, assert flush in the 2nd BUSY cycle -> hi/lo unchanged, mul_start falls next edge, stall_req=0 in the flush cycle. Repeat with flush coinciding with mul_over=1 -> still no write.
- Async reset mid-BUSY: drop rst between clock edges -> outputs clear immediately without a clock edge; the next MULT 2*3 after release gives lo=6, hi=0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// hilo_muldiv_ctrl
// EX-stage HI/LO controller: issues multiplies, stalls until done, then
// writes or accumulates the 2*DW product into HI/LO. Also handles MTHI/MTLO.
// Revision: 1.0
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [3:0]      op,
  input  logic [DW-1:0]   rs_val,
  input  logic [DW-1:0]   rt_val,
  input  logic            flush,
  input  logic [2*DW-1:0] mul_p,
  input  logic            mul_over,
  output logic            mul_start,
  output logic            mul_sign,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  output logic            stall_req,
  output logic [DW-1:0]   hi,
  output logic [DW-1:0]   lo
);

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_madd  = 4'd3;
  localparam logic [3:0] c_op_maddu = 4'd4;
  localparam logic [3:0] c_op_msub  = 4'd5;
  localparam logic [3:0] c_op_msubu = 4'd6;
  localparam logic [3:0] c_op_mthi  = 4'd7;
  localparam logic [3:0] c_op_mtlo  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_op;
  logic            r_mul_start;
  logic            r_mul_sign;
  logic [DW-1:0]   r_mul_a;
  logic [DW-1:0]   r_mul_b;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;

  logic            w_is_mul;
  logic            w_is_signed;
  logic            w_issue;
  logic            w_done;
  logic            w_leave_busy;
  logic            w_move_hi;
  logic            w_move_lo;
  logic            w_stall;
  logic [2*DW-1:0] w_hilo;
  logic [2*DW-1:0] w_hilo_nxt;

  always_comb begin
    w_is_mul    = 1'b0;
    w_is_signed = 1'b0;
    case (op)
      c_op_mult, c_op_madd, c_op_msub: begin
        w_is_mul    = 1'b1;
        w_is_signed = 1'b1;
      end
      c_op_multu, c_op_maddu, c_op_msubu: w_is_mul = 1'b1;
      default: ;
    endcase
  end

  // Next state and control. In BUSY the EX inputs are ignored; flush wins over mul_over.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    w_leave_busy = 1'b0;
    w_move_hi    = 1'b0;
    w_move_lo    = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          if (w_is_mul) begin
            w_issue     = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = ST_BUSY;
          end else if (op == c_op_mthi) begin
            w_move_hi = 1'b1;
          end else if (op == c_op_mtlo) begin
            w_move_lo = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          w_leave_busy = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (mul_over) begin
          w_done       = 1'b1;
          w_leave_busy = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_hilo = {r_hi, r_lo};

  always_comb begin
    w_hilo_nxt = mul_p;
    case (r_op)
      c_op_madd, c_op_maddu: w_hilo_nxt = w_hilo + mul_p;
      c_op_msub, c_op_msubu: w_hilo_nxt = w_hilo - mul_p;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_op        <= 4'd0;
      r_mul_start <= 1'b0;
      r_mul_sign  <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_op        <= op;
        r_mul_start <= 1'b1;
        r_mul_sign  <= w_is_signed;
        r_mul_a     <= rs_val;
        r_mul_b     <= rt_val;
      end else if (w_leave_busy) begin
        r_mul_start <= 1'b0;
      end
      if (w_done) begin
        {r_hi, r_lo} <= w_hilo_nxt;
      end else begin
        if (w_move_hi) r_hi <= rs_val;
        if (w_move_lo) r_lo <= rs_val;
      end
    end
  end

  assign mul_start = r_mul_start;
  assign mul_sign  = r_mul_sign;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign stall_req = rst & w_stall;

endmodule
`default_nettype wire
